// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the IF/ID/EX hazard controller: FSM states and the
// bundle of pipeline enables/flushes it drives.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_STALL    = 2'd1,
    CTRL_MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = '0;

  // Remaining-stall counter width; comfortably holds any configured stall length.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t OUT_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t OUT_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t OUT_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t OUT_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// Combinational rs/rd comparison: returns how many bubbles the ID
// instruction needs given the instruction currently in EX (0 = none).
module pipe_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int LOAD_BR_STALL  = 2,
  parameter int ALU_BR_STALL   = 1
) (
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             id_branch,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  output logic [CNT_W-1:0] stall_n
);

  logic match;

  // x0 is hardwired, so a write to it can never create a dependency.
  assign match = (ex_rd_addr != REG_ZERO) &&
                 ((rs1_used && (rs1_addr == ex_rd_addr)) ||
                  (rs2_used && (rs2_addr == ex_rd_addr)));

  always_comb begin
    stall_n = '0;
    if (ex_mem_read && match && id_branch)
      stall_n = CNT_W'(LOAD_BR_STALL);
    else if (ex_mem_read && match)
      stall_n = CNT_W'(LOAD_USE_STALL);
    else if (ex_reg_write && !ex_mem_read && match && id_branch)
      stall_n = CNT_W'(ALU_BR_STALL);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: bubbles, IF/ID flush on redirect, freeze on busy memory.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int LOAD_BR_STALL  = 2,
  parameter int ALU_BR_STALL   = 1
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int PERF_WIDTH     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            ID_rs1_addr_i,
  input  logic [4:0]            ID_rs2_addr_i,
  input  logic                  ID_rs1_used_i,
  input  logic                  ID_rs2_used_i,
  input  logic                  ID_Branch_i,
  input  logic                  ID_PCSrc_i,
  input  logic [4:0]            EX_rd_addr_i,
  input  logic                  EX_RegWrite_i,
  input  logic                  EX_MemRead_i,
  input  logic                  MEM_busy_i,
  output logic                  PC_we_o,
  output logic                  IF_ID_we_o,
  output logic                  IF_ID_flush_o,
  output logic                  ID_EX_we_o,
  output logic                  ID_EX_flush_o,
  output logic                  EX_MEM_we_o,
  output logic [1:0]            ctrl_state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cycles_o,
  output logic [PERF_WIDTH-1:0] flush_cnt_o
`endif
);

  ctrl_state_e      state_q, state_d, ret_q, ret_d, eval_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, stall_n;
  pipe_ctrl_t       ctl;

  pipe_hazard_detect #(
    .LOAD_USE_STALL(LOAD_USE_STALL),
    .LOAD_BR_STALL (LOAD_BR_STALL),
    .ALU_BR_STALL  (ALU_BR_STALL)
  ) u_detect (
    .rs1_addr    (ID_rs1_addr_i),
    .rs2_addr    (ID_rs2_addr_i),
    .rs1_used    (ID_rs1_used_i),
    .rs2_used    (ID_rs2_used_i),
    .id_branch   (ID_Branch_i),
    .ex_rd_addr  (EX_rd_addr_i),
    .ex_reg_write(EX_RegWrite_i),
    .ex_mem_read (EX_MemRead_i),
    .stall_n     (stall_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_RUN;
      ret_q   <= CTRL_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    ctl     = OUT_RUN;
    // On release from MEM_WAIT the saved state is acted on in the same cycle.
    eval_state = (state_q == CTRL_MEM_WAIT) ? ret_q : state_q;
    if (MEM_busy_i) begin
      ctl = OUT_FREEZE;
      if (state_q != CTRL_MEM_WAIT) begin
        ret_d   = state_q;
        state_d = CTRL_MEM_WAIT;
      end
    end else if (rst) begin
      ctl = OUT_RUN;
    end else begin
      state_d = eval_state;
      case (eval_state)
        CTRL_STALL: begin
          // Hazard inputs and ID_PCSrc_i are stale here and deliberately ignored.
          ctl   = OUT_STALL;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = CTRL_RUN;
        end
        default: begin
          if (stall_n != '0) begin
            ctl = OUT_STALL;
            if (stall_n > CNT_W'(1)) begin
              cnt_d   = stall_n - CNT_W'(1);
              state_d = CTRL_STALL;
            end
          end else if (ID_PCSrc_i) begin
            ctl = OUT_FLUSH;
          end
        end
      endcase
    end
  end

  assign PC_we_o       = ctl.pc_we;
  assign IF_ID_we_o    = ctl.if_id_we;
  assign IF_ID_flush_o = ctl.if_id_flush;
  assign ID_EX_we_o    = ctl.id_ex_we;
  assign ID_EX_flush_o = ctl.id_ex_flush;
  assign EX_MEM_we_o   = ctl.ex_mem_we;
  assign ctrl_state_o  = state_q;

`ifdef PIPE_PERF_CNT_EN
  // Stall and freeze are exactly the cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (!ctl.pc_we)      stall_cycles_o <= stall_cycles_o + PERF_WIDTH'(1);
      if (ctl.if_id_flush) flush_cnt_o    <= flush_cnt_o + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step pushes its expected
// enables/state to a queue and the value is popped and checked at negedge.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] E_RUN    = 6'b110101;
  localparam logic [5:0] E_STALL  = 6'b000111;
  localparam logic [5:0] E_FLUSH  = 6'b111101;
  localparam logic [5:0] E_FREEZE = 6'b000000;
  localparam logic [1:0] S_RUN = 2'd0, S_STL = 2'd1, S_MW = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, br, pcs, rw, mr, busy;
  logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cnt;
`endif

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         errors = 0;
  int         checks = 0;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1_addr_i(rs1),
    .ID_rs2_addr_i(rs2),
    .ID_rs1_used_i(u1),
    .ID_rs2_used_i(u2),
    .ID_Branch_i  (br),
    .ID_PCSrc_i   (pcs),
    .EX_rd_addr_i (rd),
    .EX_RegWrite_i(rw),
    .EX_MemRead_i (mr),
    .MEM_busy_i   (busy),
    .PC_we_o      (pc_we),
    .IF_ID_we_o   (if_id_we),
    .IF_ID_flush_o(if_id_flush),
    .ID_EX_we_o   (id_ex_we),
    .ID_EX_flush_o(id_ex_flush),
    .EX_MEM_we_o  (ex_mem_we),
    .ctrl_state_o (state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles_o(stall_cycles),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, queue the expected outputs, check at negedge.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2,
                      input logic i_u1, input logic i_u2, input logic i_br,
                      input logic i_pcs, input logic [4:0] i_rd, input logic i_rw,
                      input logic i_mr, input logic i_busy,
                      input logic [5:0] e_out, input logic [1:0] e_st, input string tag);
    logic [7:0] exp_v, got_v;
    string      t;
    rs1 = a1; rs2 = a2; u1 = i_u1; u2 = i_u2; br = i_br; pcs = i_pcs;
    rd = i_rd; rw = i_rw; mr = i_mr; busy = i_busy;
    exp_q.push_back({e_out, e_st});
    tag_q.push_back(tag);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    got_v = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, state};
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s: got {we/flush,state}=%b expected=%b", t, got_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 0; u2 = 0; br = 0; pcs = 0; rw = 0; mr = 0; busy = 0;
    @(posedge clk);
    #1;
    // Reset: enables forced high regardless of hazards, unless memory is busy.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,    S_RUN, "rst_idle");
    step(6, 1, 1, 1, 0, 0, 6, 1, 1, 0, E_RUN,    S_RUN, "rst_hazard");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_FREEZE, S_RUN, "rst_busy");
    rst = 1'b0;

    // lw x1 in EX, beq x1,x2 taken in ID: two bubbles, then the redirect.
    step(1, 2, 1, 1, 1, 1, 1, 1, 1, 0, E_STALL, S_RUN, "ldbr_s1");
    step(1, 2, 1, 1, 1, 1, 1, 1, 1, 0, E_STALL, S_STL, "ldbr_s2");
    step(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, E_FLUSH, S_RUN, "ldbr_flush");
`ifdef PIPE_PERF_CNT_EN
    checks++;
    assert (stall_cycles === 32'd2) else begin
      errors++;
      $error("FAIL perf_stall: got=%0d expected=2", stall_cycles);
    end
    checks++;
    assert (flush_cnt === 32'd1) else begin
      errors++;
      $error("FAIL perf_flush: got=%0d expected=1", flush_cnt);
    end
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, S_RUN, "ldbr_after");

    // lw x6 in EX, add x4,x6,x1 in ID: single load-use bubble.
    step(6, 1, 1, 1, 0, 0, 6, 1, 1, 0, E_STALL, S_RUN, "lu_stall");
    step(6, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_RUN,   S_RUN, "lu_after");
    step(3, 6, 1, 0, 0, 0, 6, 1, 1, 0, E_RUN,   S_RUN, "lu_rs2_unused");
    step(0, 3, 1, 1, 0, 0, 0, 1, 1, 0, E_RUN,   S_RUN, "lu_x0");

    // ALU result needed by a branch: one bubble; x0 and non-branch users don't stall.
    step(1, 2, 1, 1, 1, 0, 1, 1, 0, 0, E_STALL, S_RUN, "alubr_stall");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, E_RUN,   S_RUN, "alubr_after");
    step(0, 2, 1, 1, 1, 0, 0, 1, 0, 0, E_RUN,   S_RUN, "alubr_x0");
    step(1, 2, 1, 1, 0, 0, 1, 1, 0, 0, E_RUN,   S_RUN, "alu_nonbranch");
    step(3, 1, 1, 1, 1, 0, 1, 1, 0, 0, E_STALL, S_RUN, "alubr_rs2");
    step(3, 1, 1, 1, 1, 0, 0, 0, 0, 0, E_RUN,   S_RUN, "alubr_rs2_after");

    // Freeze during the second load-branch bubble; the bubble completes on release.
    step(1, 2, 1, 1, 1, 0, 1, 1, 1, 0, E_STALL,  S_RUN, "frz_s1");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 1, E_FREEZE, S_STL, "frz_c1");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 1, E_FREEZE, S_MW,  "frz_c2");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 1, E_FREEZE, S_MW,  "frz_c3");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, E_STALL,  S_MW,  "frz_release");
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, E_RUN,    S_RUN, "frz_after");

    // Freeze in RUN with a pending redirect: the redirect goes out on release.
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, E_FREEZE, S_RUN, "runfrz_busy");
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, E_FLUSH,  S_MW,  "runfrz_release");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,    S_RUN, "runfrz_after");

    // Reset while a load-branch stall still has a cycle left.
    step(1, 2, 1, 1, 1, 0, 1, 1, 1, 0, E_STALL, S_RUN, "rststl_s1");
    rst = 1'b1;
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, E_RUN, S_RUN, "rststl_in_reset");
    rst = 1'b0;
    step(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, E_RUN, S_RUN, "rststl_after");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: got=%0d entries expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
